// File: rtl/cdc_rd_packer_pkg.sv
// Shared types and width helpers for the CDC read-side byte packer.
package cdc_rd_packer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Width needed to hold a byte count of 0..n.
  function automatic int unsigned nbytes_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cdc_rd_packer_if.sv
// FIFO read port plus packed-word valid/ready stream seen by cdc_rd_packer.
interface cdc_rd_packer_if
  import cdc_rd_packer_pkg::*;
#(
  parameter int unsigned N = 2
) ();

  byte_t                    rdata;
  logic                     rrdy;
  logic                     rget;
  logic [BYTE_W*N-1:0]      out_data;
  logic [nbytes_w(N)-1:0]   out_nbytes;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  rdata, rrdy, out_ready,
    output rget, out_data, out_nbytes, out_valid
  );

  modport slave (
    output rdata, rrdy, out_ready,
    input  rget, out_data, out_nbytes, out_valid
  );

endinterface

// File: rtl/cdc_rd_packer_sync_fifo2.sv
// Two-entry synchronous FIFO with registered head; push and pop may coincide.
module sync_fifo2 #(
  parameter type T = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  T           wdata,
  input  logic       push,
  output T           rdata,
  input  logic       pop,
  output logic [1:0] count
);

  T           head_q, head_d;
  T           tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_pop;

  assign do_pop = pop && (cnt_q != 2'd0);

  // Pop first, then place the new entry behind whatever remains.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (do_pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) head_d = wdata;
      else               tail_d = wdata;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/cdc_rd_packer.sv
// Drains the CDC FIFO read port, packs N bytes little-endian per word, and
// queues packed or flushed partial words onto a valid/ready stream.
module cdc_rd_packer
  import cdc_rd_packer_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  cdc_rd_packer_if.master bus
);

  localparam int unsigned    NBW  = nbytes_w(N);
  localparam int unsigned    IW   = $clog2(N);
  localparam logic [IW-1:0]  LAST = IW'(N - 1);

  typedef struct packed {
    logic [BYTE_W*N-1:0] data;
    logic [NBW-1:0]      nbytes;
  } entry_t;

  logic [IW-1:0]       idx_q, idx_d;
  logic [BYTE_W*N-1:0] acc_q, acc_d, acc_ins;
  logic                flush_pend_q, flush_pend_d;
  entry_t              push_entry, head;
  logic                push, pop, space, rget, word_done, flush_push;
  logic [1:0]          count;

  assign pop        = bus.out_valid && bus.out_ready;
  assign space      = (count < 2'd2) || pop;
  assign rget       = rst_n && bus.rrdy && !flush_pend_q && ((idx_q != LAST) || space);
  assign word_done  = rget && (idx_q == LAST);
  assign flush_push = flush_pend_q && (idx_q != '0) && space;
  assign push       = word_done || flush_push;

  always_comb begin
    acc_ins = acc_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) acc_ins[i*BYTE_W +: BYTE_W] = bus.rdata;
    end
  end

  // rget is held low while a flush is pending, so byte capture and the
  // flush push never happen on the same edge.
  always_comb begin
    idx_d             = idx_q;
    acc_d             = acc_q;
    flush_pend_d      = flush_pend_q;
    push_entry.data   = acc_ins;
    push_entry.nbytes = NBW'(N);
    if (word_done) begin
      idx_d = '0;
      acc_d = '0;
    end else if (rget) begin
      idx_d = idx_q + 1'b1;
      acc_d = acc_ins;
    end
    if (flush_pend_q) begin
      if (idx_q == '0) begin
        flush_pend_d = 1'b0;
      end else if (space) begin
        flush_pend_d      = 1'b0;
        idx_d             = '0;
        acc_d             = '0;
        push_entry.data   = acc_q;
        push_entry.nbytes = NBW'(idx_q);
      end
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  sync_fifo2 #(
    .T(entry_t)
  ) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .wdata(push_entry),
    .push (push),
    .rdata(head),
    .pop  (pop),
    .count(count)
  );

  assign bus.rget       = rget;
  assign bus.out_data   = head.data;
  assign bus.out_nbytes = head.nbytes;
  assign bus.out_valid  = (count != 2'd0);

endmodule

// File: tb/tb_cdc_rd_packer.sv
// Directed and random checks of cdc_rd_packer with N=2 and N=4 instances.
module tb_cdc_rd_packer;

  logic clk;
  logic rst_n;
  logic flush2, flush4;
  int   n_checks = 0;
  int   n_fail   = 0;

  cdc_rd_packer_if #(.N(2)) b2 ();
  cdc_rd_packer_if #(.N(4)) b4 ();

  cdc_rd_packer #(.N(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .flush(flush2), .bus(b2));
  cdc_rd_packer #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .flush(flush4), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_rget2: assert property (@(posedge clk) b2.rget |-> b2.rrdy);
  a_rget4: assert property (@(posedge clk) b4.rget |-> b4.rrdy);

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected end of run");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0; b2.rrdy = 1'b1; b4.rrdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (b2.rget !== 1'b0) begin n_fail++; $display("FAIL reset_rget2: got %b want 0", b2.rget); end
    n_checks++; if (b2.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b want 0", b2.out_valid); end
    n_checks++; if (b2.out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data2: got %h want 0000", b2.out_data); end
    n_checks++; if (b2.out_nbytes !== 2'd0) begin n_fail++; $display("FAIL reset_nbytes2: got %0d want 0", b2.out_nbytes); end
    n_checks++; if (b4.rget !== 1'b0) begin n_fail++; $display("FAIL reset_rget4: got %b want 0", b4.rget); end
    n_checks++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %b want 0", b4.out_valid); end
    n_checks++; if (b4.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data4: got %h want 00000000", b4.out_data); end
    n_checks++; if (b4.out_nbytes !== 3'd0) begin n_fail++; $display("FAIL reset_nbytes4: got %0d want 0", b4.out_nbytes); end
    b2.rrdy = 1'b0; b4.rrdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0]  bytes [4];
    logic        ev [6];
    logic [15:0] ed [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    ev    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ed    = '{16'h0, 16'h0, 16'h2211, 16'h0, 16'h4433, 16'h0};
    b2.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      b2.rrdy  = (k < 4);
      b2.rdata = (k < 4) ? bytes[k] : 8'h00;
      #1;
      n_checks++; if (b2.rget !== (k < 4)) begin n_fail++; $display("FAIL basic_rget[%0d]: got %b want %b", k, b2.rget, (k < 4)); end
      n_checks++; if (b2.out_valid !== ev[k]) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b want %b", k, b2.out_valid, ev[k]); end
      if (ev[k]) begin
        n_checks++; if (b2.out_data !== ed[k] || b2.out_nbytes !== 2'd2) begin
          n_fail++; $display("FAIL basic_word[%0d]: got %h/%0d want %h/2", k, b2.out_data, b2.out_nbytes, ed[k]);
        end
      end
    end
  endtask

  task automatic test_partial_flush();
    logic        rr [11];
    logic [7:0]  rd [11];
    logic        fl [11];
    logic        er [11];
    logic        ev [11];
    logic [31:0] ed [11];
    logic [2:0]  en [11];
    rr = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
    rd = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'hD4, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h00, 8'h00};
    fl = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    er = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    ev = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    ed = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00C3B2A1, 32'h0, 32'h0, 32'h0, 32'h07F6E5D4, 32'h0};
    en = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0};
    b4.out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      b4.rrdy = rr[k]; b4.rdata = rd[k]; flush4 = fl[k];
      #1;
      n_checks++; if (b4.rget !== er[k]) begin n_fail++; $display("FAIL pflush_rget[%0d]: got %b want %b", k, b4.rget, er[k]); end
      n_checks++; if (b4.out_valid !== ev[k]) begin n_fail++; $display("FAIL pflush_valid[%0d]: got %b want %b", k, b4.out_valid, ev[k]); end
      if (ev[k]) begin
        n_checks++; if (b4.out_data !== ed[k] || b4.out_nbytes !== en[k]) begin
          n_fail++; $display("FAIL pflush_word[%0d]: got %h/%0d want %h/%0d", k, b4.out_data, b4.out_nbytes, ed[k], en[k]);
        end
      end
    end
    flush4 = 1'b0;
  endtask

  task automatic test_empty_flush();
    @(negedge clk);
    flush4 = 1'b1; b4.rrdy = 1'b0;
    #1;
    n_checks++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL eflush_valid0: got %b want 0", b4.out_valid); end
    @(negedge clk);
    flush4 = 1'b0; b4.rrdy = 1'b1; b4.rdata = 8'h55;
    #1;
    n_checks++; if (b4.rget !== 1'b0) begin n_fail++; $display("FAIL eflush_rget_pend: got %b want 0", b4.rget); end
    b4.rrdy = 1'b0;
    @(negedge clk);
    b4.rrdy = 1'b1; b4.rdata = 8'h66;
    #1;
    n_checks++; if (b4.rget !== 1'b1) begin n_fail++; $display("FAIL eflush_rget_clear: got %b want 1", b4.rget); end
    b4.rrdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      n_checks++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL eflush_novalid[%0d]: got %b want 0", k, b4.out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  b;
    logic        dr [4];
    logic        dg [4];
    logic        dv [4];
    logic [15:0] dd [4];
    dr = '{1, 0, 0, 0};
    dg = '{1, 0, 0, 0};
    dv = '{1, 1, 1, 0};
    dd = '{16'h0201, 16'h0403, 16'h0605, 16'h0};
    b2.out_ready = 1'b0;
    b = 8'h01;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b2.rrdy = 1'b1; b2.rdata = b;
      #1;
      n_checks++; if (b2.rget !== (k < 5)) begin n_fail++; $display("FAIL bp_rget[%0d]: got %b want %b", k, b2.rget, (k < 5)); end
      if (k >= 5) begin
        n_checks++; if (b2.out_valid !== 1'b1 || b2.out_data !== 16'h0201 || b2.out_nbytes !== 2'd2) begin
          n_fail++; $display("FAIL bp_hold[%0d]: got %b %h/%0d want 1 0201/2", k, b2.out_valid, b2.out_data, b2.out_nbytes);
        end
      end
      if (k < 5) b = b + 8'h01;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b2.out_ready = 1'b1; b2.rrdy = dr[k]; b2.rdata = 8'h06;
      #1;
      n_checks++; if (b2.rget !== dg[k]) begin n_fail++; $display("FAIL drain_rget[%0d]: got %b want %b", k, b2.rget, dg[k]); end
      n_checks++; if (b2.out_valid !== dv[k]) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want %b", k, b2.out_valid, dv[k]); end
      if (dv[k]) begin
        n_checks++; if (b2.out_data !== dd[k] || b2.out_nbytes !== 2'd2) begin
          n_fail++; $display("FAIL drain_word[%0d]: got %h/%0d want %h/2", k, b2.out_data, b2.out_nbytes, dd[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] bytes [3];
    bytes = '{8'h91, 8'h92, 8'h93};
    b2.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b2.rrdy = 1'b1; b2.rdata = bytes[k];
      #1;
      n_checks++; if (b2.rget !== 1'b1) begin n_fail++; $display("FAIL rstmid_rget[%0d]: got %b want 1", k, b2.rget); end
    end
    @(negedge clk);
    b2.rdata = 8'h94;
    #1;
    n_checks++; if (b2.rget !== 1'b1 || b2.out_valid !== 1'b1 || b2.out_data !== 16'h9291) begin
      n_fail++; $display("FAIL rstmid_pre: got rget=%b valid=%b %h want 1 1 9291", b2.rget, b2.out_valid, b2.out_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (b2.rget !== 1'b0 || b2.out_valid !== 1'b0 || b2.out_data !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_async: got rget=%b valid=%b %h want 0 0 0000", b2.rget, b2.out_valid, b2.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1; b2.rrdy = 1'b1; b2.rdata = 8'hA0; b2.out_ready = 1'b1;
    #1;
    n_checks++; if (b2.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_post0: got %b want 0", b2.out_valid); end
    @(negedge clk);
    b2.rdata = 8'hA1;
    #1;
    n_checks++; if (b2.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_post1: got %b want 0", b2.out_valid); end
    @(negedge clk);
    b2.rrdy = 1'b0;
    #1;
    n_checks++; if (b2.out_valid !== 1'b1 || b2.out_data !== 16'hA1A0 || b2.out_nbytes !== 2'd2) begin
      n_fail++; $display("FAIL rstmid_word: got %b %h/%0d want 1 a1a0/2", b2.out_valid, b2.out_data, b2.out_nbytes);
    end
    @(negedge clk);
    #1;
    n_checks++; if (b2.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_empty: got %b want 0", b2.out_valid); end
  endtask

  // Reference model packs the byte stream the bench supplied; flush takes the
  // current partial word (including a byte taken on the same edge).
  task automatic test_random();
    logic [15:0] q_d [$];
    int          q_n [$];
    logic [15:0] cur_d, exp_d;
    int          cur_n, exp_n;
    logic [7:0]  nb;
    cur_d = '0; cur_n = 0; nb = 8'($urandom);
    for (int i = 0; i < 10020; i++) begin
      @(negedge clk);
      if (i < 10000) begin
        b2.rrdy      = ($urandom_range(0, 3) != 0);
        b2.out_ready = ($urandom_range(0, 3) != 0);
        flush2       = ($urandom_range(0, 15) == 0);
      end else begin
        b2.rrdy = 1'b0; b2.out_ready = 1'b1; flush2 = (i == 10000);
      end
      b2.rdata = nb;
      #1;
      n_checks++; if (b2.rget && !b2.rrdy) begin n_fail++; $display("FAIL rnd_proto[%0d]: rget=1 with rrdy=0", i); end
      if (b2.out_valid && b2.out_ready) begin
        n_checks++;
        if (q_d.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra[%0d]: got %h/%0d want no word", i, b2.out_data, b2.out_nbytes);
        end else begin
          exp_d = q_d.pop_front(); exp_n = q_n.pop_front();
          if (b2.out_data !== exp_d || b2.out_nbytes !== 2'(exp_n)) begin
            n_fail++; $display("FAIL rnd_word[%0d]: got %h/%0d want %h/%0d", i, b2.out_data, b2.out_nbytes, exp_d, exp_n);
          end
        end
      end
      if (b2.rget) begin
        cur_d[cur_n*8 +: 8] = nb;
        cur_n++;
        nb = 8'($urandom);
        if (cur_n == 2) begin q_d.push_back(cur_d); q_n.push_back(2); cur_d = '0; cur_n = 0; end
      end
      if (flush2 && cur_n > 0) begin
        q_d.push_back(cur_d); q_n.push_back(cur_n); cur_d = '0; cur_n = 0;
      end
    end
    flush2 = 1'b0;
    n_checks++; if (q_d.size() != 0 || b2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain: got %0d words pending, valid=%b want 0 0", q_d.size(), b2.out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush2 = 1'b0; flush4 = 1'b0;
    b2.rrdy = 1'b0; b2.rdata = '0; b2.out_ready = 1'b0;
    b4.rrdy = 1'b0; b4.rdata = '0; b4.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_partial_flush();
    test_empty_flush();
    test_backpressure();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
